// File: rtl/branch_flush_ctrl_pkg.sv
// Shared types and constants for the branch tag / flush sequencer and its predictor table.
package branch_flush_ctrl_pkg;

  localparam int TAG_W = 2;
  localparam int PC_W  = 13;

  localparam logic [1:0] PHT_INIT = 2'b01;
  localparam logic [1:0] PHT_MAX  = 2'b11;
  localparam logic [1:0] PHT_MIN  = 2'b00;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/branch_pht.sv
// Table of 2-bit saturating direction counters: combinational read, update on the clock edge.
module branch_pht
  import branch_flush_ctrl_pkg::*;
#(
  parameter int PHT_IDX_W = 4
) (
  input  logic            CLK,
  input  logic            NRST,
  input  logic [PC_W-1:0] rd_pc,
  output logic [1:0]      rd_state,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic            wr_taken
);

  localparam int DEPTH = 1 << PHT_IDX_W;

  logic [1:0]           cnt_q [DEPTH];
  logic [PHT_IDX_W-1:0] rd_idx;
  logic [PHT_IDX_W-1:0] wr_idx;
  logic                 unused_pc_bits;

  function automatic logic [1:0] sat_update(input logic [1:0] cur, input logic up);
    if (up) return (cur == PHT_MAX) ? cur : cur + 2'd1;
    return (cur == PHT_MIN) ? cur : cur - 2'd1;
  endfunction

  // Instructions are word aligned, so the index skips the two byte-offset bits.
  assign rd_idx = rd_pc[PHT_IDX_W+1:2];
  assign wr_idx = wr_pc[PHT_IDX_W+1:2];
  assign unused_pc_bits = ^{rd_pc[1:0], rd_pc[PC_W-1:PHT_IDX_W+2],
                            wr_pc[1:0], wr_pc[PC_W-1:PHT_IDX_W+2]};

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= PHT_INIT;
    end else if (wr_en) begin
      cnt_q[wr_idx] <= sat_update(cnt_q[wr_idx], wr_taken);
    end
  end

  assign rd_state = cnt_q[rd_idx];

endmodule

// File: rtl/branch_flush_ctrl.sv
// Branch tag ring, in-order retire, mispredict flush/redirect and D/E stall generation.
// Optional predictor table enabled by defining BRANCH_FLUSH_CTRL_PHT_EN.
module branch_flush_ctrl
  import branch_flush_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int PHT_IDX_W    = 4
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             load_use,
  input  logic             br_decD,
  input  logic [PC_W-1:0]  pcD,
  output logic [TAG_W-1:0] branch_numberD,
  output logic [1:0]       stateD,
  input  logic             res_valid,
  input  logic [TAG_W-1:0] res_tag,
  input  logic [PC_W-1:0]  res_pc,
  input  logic             res_taken,
  input  logic             res_mispredict,
  input  logic [PC_W-1:0]  res_target,
  output logic             stall,
  output logic             fail_predict,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             tag_error
);

  localparam logic [1:0]     FLUSH_INIT = 2'(FLUSH_CYCLES);
  localparam logic [TAG_W:0] TAGS_ALL   = (TAG_W+1)'(1 << TAG_W);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  fsm_state_t       state_q, state_d;
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [1:0]       flush_cnt_q, flush_cnt_d;
  logic             redirect_valid_d, tag_error_d;
  logic [PC_W-1:0]  redirect_pc_d;
  logic             running, alloc, in_order;

  assign running        = (state_q == RUN);
  assign stall          = (load_use | (br_decD & (count_q == TAGS_ALL))) & running;
  assign alloc          = br_decD & ~stall & running;
  assign in_order       = res_valid & running & (res_tag == head_q);
  assign fail_predict   = (state_q == FLUSH);
  assign branch_numberD = tail_q;

  always_comb begin
    state_d          = state_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    flush_cnt_d      = flush_cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q_hold();
    tag_error_d      = tag_error;
    case (state_q)
      RUN: begin
        if (res_valid && (res_tag != head_q)) tag_error_d = 1'b1;
        // A mispredict squashes every younger tag, including any allocation this cycle.
        if (in_order && res_mispredict) begin
          state_d          = FLUSH;
          flush_cnt_d      = FLUSH_INIT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = res_target;
          head_d           = head_q + TAG_ONE;
          tail_d           = head_q + TAG_ONE;
          count_d          = '0;
        end else begin
          if (alloc)    tail_d = tail_q + TAG_ONE;
          if (in_order) head_d = head_q + TAG_ONE;
          if (alloc && !in_order)      count_d = count_q + 1'b1;
          else if (!alloc && in_order) count_d = count_q - 1'b1;
        end
      end
      FLUSH: begin
        if (flush_cnt_q <= 2'd1) state_d = RUN;
        else                     flush_cnt_d = flush_cnt_q - 2'd1;
      end
      default: state_d = RUN;
    endcase
  end

  function automatic logic [PC_W-1:0] redirect_pc_q_hold();
    return redirect_pc;
  endfunction

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q        <= RUN;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      flush_cnt_q    <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      tag_error      <= 1'b0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      flush_cnt_q    <= flush_cnt_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      tag_error      <= tag_error_d;
    end
  end

`ifdef BRANCH_FLUSH_CTRL_PHT_EN
  branch_pht #(
    .PHT_IDX_W (PHT_IDX_W)
  ) u_pht (
    .CLK      (CLK),
    .NRST     (NRST),
    .rd_pc    (pcD),
    .rd_state (stateD),
    .wr_en    (in_order),
    .wr_pc    (res_pc),
    .wr_taken (res_taken)
  );
`else
  localparam int unused_idx_w = PHT_IDX_W;
  logic unused_pht_inputs;
  assign unused_pht_inputs = ^{pcD, res_pc, res_taken};
  assign stateD = PHT_INIT;
`endif

endmodule
